// File: rtl/half_act_pkg.sv
// Shared types and fp16 constants for the half-precision activation sequencer.
// Optional feature macro: HALF_ACT_NAN_PROPAGATE_EN (NaN inputs collapse to a canonical quiet NaN).
package half_act_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_RELU     = 2'd1,
    MODE_LEAKY    = 2'd2,
    MODE_HARDTANH = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic [15:0] HALF_ONE      = 16'h3C00;
  localparam logic [15:0] HALF_QNAN     = 16'h7E00;
  localparam logic [15:0] HALF_NEG_ZERO = 16'h8000;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

endpackage

// File: rtl/half_act_lane.sv
// One fp16 activation lane with a registered result.
// Optional feature macro: HALF_ACT_NAN_PROPAGATE_EN.
module half_act_lane
  import half_act_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  act_mode_e   mode,
  input  logic [15:0] a,
  output logic [15:0] c
);

  logic [15:0] res;

  always_comb begin
    res = a;
    case (mode)
      MODE_RELU: begin
        if (a[15]) res = 16'h0000;
      end
      // Divide by 8 via exponent; negatives too small to stay normal flush to -0.
      MODE_LEAKY: begin
        if (a[15] && (a[14:10] != 5'h1F)) begin
          if (a[14:10] > 5'd3) res = {1'b1, a[14:10] - 5'd3, a[9:0]};
          else                 res = HALF_NEG_ZERO;
        end
      end
      MODE_HARDTANH: begin
        if (a[14:0] > HALF_ONE[14:0]) res = {a[15], HALF_ONE[14:0]};
      end
      default: res = a;
    endcase
`ifdef HALF_ACT_NAN_PROPAGATE_EN
    if (is_nan(a)) res = HALF_QNAN;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) c <= 16'h0000;
    else     c <= res;
  end

endmodule

// File: rtl/half_activation_seq_v.sv
// Sequences an fp16 vector through LANES activation lanes, BEATS beats per vector.
// Optional feature macro: HALF_ACT_NAN_PROPAGATE_EN (passed through to the lanes).
module half_activation_seq_v
  import half_act_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mode,
  input  logic [15:0] vector_a [WIDTH],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] vector_c [WIDTH]
);

  localparam int BEATS = (WIDTH + LANES - 1) / LANES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS);

  seq_state_e  state, next_state;
  act_mode_e   mode_q;
  logic [15:0] a_reg [WIDTH];
  logic [BW-1:0] beat_cnt, wr_beat_q;
  logic        wr_en_q;
  logic        accept;
  logic [15:0] lane_in  [LANES];
  logic [15:0] lane_out [LANES];

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // RUN lasts BEATS issue cycles plus one drain cycle for the last lane result.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (in_valid)               next_state = ST_RUN;
      ST_RUN:  if (beat_cnt == LAST_BEAT)  next_state = ST_DONE;
      ST_DONE: if (out_ready)              next_state = ST_IDLE;
      default:                             next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    out_valid = (state == ST_DONE);
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = 16'h0000;
      for (int i = 0; i < WIDTH; i++) begin
        if (i == int'(beat_cnt) * LANES + l) lane_in[l] = a_reg[i];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    half_act_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .mode (mode_q),
      .a    (lane_in[l]),
      .c    (lane_out[l])
    );
  end

  // Lane results land one cycle after issue; padded indices never match a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      wr_beat_q <= '0;
      wr_en_q   <= 1'b0;
      mode_q    <= MODE_PASS;
      for (int i = 0; i < WIDTH; i++) begin
        a_reg[i]    <= 16'h0000;
        vector_c[i] <= 16'h0000;
      end
    end else begin
      if (accept) begin
        mode_q   <= act_mode_e'(mode);
        beat_cnt <= '0;
        for (int i = 0; i < WIDTH; i++) a_reg[i] <= vector_a[i];
      end
      if (state == ST_RUN) begin
        wr_en_q   <= (beat_cnt != LAST_BEAT);
        wr_beat_q <= beat_cnt;
        if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
        else                       beat_cnt <= beat_cnt + 1'b1;
      end else begin
        wr_en_q <= 1'b0;
      end
      if (wr_en_q) begin
        for (int l = 0; l < LANES; l++) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(wr_beat_q) * LANES + l) vector_c[i] <= lane_out[l];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_half_activation_seq_v.sv
// Directed bench for half_activation_seq_v: a WIDTH=10/LANES=2 instance and a WIDTH=5 instance.
// Expectations for NaN inputs follow HALF_ACT_NAN_PROPAGATE_EN.
module tb_half_activation_seq_v;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [1:0]  mode_a;
  logic [15:0] va_a [10];
  logic [15:0] vc_a [10];
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [1:0]  mode_b;
  logic [15:0] va_b [5];
  logic [15:0] vc_b [5];

  logic [15:0] exp_a [10];
  logic [15:0] exp_b [5];
  int          tests = 0;
  int          failures = 0;
  int          cycles;
  logic [15:0] nan_exp, ht_nan_exp;

  always #5 clk = ~clk;

  half_activation_seq_v #(.WIDTH(10), .LANES(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .mode(mode_a), .vector_a(va_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .vector_c(vc_a)
  );

  half_activation_seq_v #(.WIDTH(5), .LANES(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .mode(mode_b), .vector_a(va_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .vector_c(vc_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Present one vector to instance A and count cycles from the accept edge to out_valid.
  task automatic apply_stimulus_a(input logic [1:0] m);
    mode_a     = m;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    cycles = 0;
    while (out_valid_a !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  task automatic drain_a();
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
  endtask

  task automatic check_vector_a(input string tag);
    for (int i = 0; i < 10; i++) check_output($sformatf("%s_c%0d", tag, i), vc_a[i], exp_a[i]);
  endtask

  initial begin
`ifdef HALF_ACT_NAN_PROPAGATE_EN
    nan_exp    = 16'h7E00;
    ht_nan_exp = 16'h7E00;
`else
    nan_exp    = 16'h7E01;
    ht_nan_exp = 16'h3C00;
`endif
    rst = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; mode_a = 2'd0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; mode_b = 2'd0;
    for (int i = 0; i < 10; i++) va_a[i] = 16'h0000;
    for (int i = 0; i < 5; i++)  va_b[i] = 16'h0000;

    step();
    step();
    check_output("rst_in_ready_low", {15'h0, in_ready_a}, 16'h0);
    rst = 1'b0;
    #1;
    check_output("reset_in_ready", {15'h0, in_ready_a}, 16'h1);
    check_output("reset_out_valid", {15'h0, out_valid_a}, 16'h0);
    check_output("reset_c0", vc_a[0], 16'h0000);
    check_output("reset_c9", vc_a[9], 16'h0000);

    // RELU, including -0, +inf and -inf
    va_a  = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h4000, 16'hC000, 16'h3800, 16'hB800};
    exp_a = '{16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h7C00, 16'h0000, 16'h4000, 16'h0000, 16'h3800, 16'h0000};
    apply_stimulus_a(2'd1);
    check_output("relu_latency", 16'(cycles), 16'd6);
    check_vector_a("relu");
    step();
    check_output("relu_hold_valid", {15'h0, out_valid_a}, 16'h1);
    drain_a();
    check_output("relu_drain_valid", {15'h0, out_valid_a}, 16'h0);
    check_output("relu_drain_ready", {15'h0, in_ready_a}, 16'h1);

    // LEAKY: -8 -> -1, tiny negatives flush, negative inf/NaN untouched
    va_a  = '{16'hC800, 16'h8C00, 16'hFC00, 16'h3C00, 16'h8400, 16'hC000, 16'h7E01, 16'hFE01, 16'h8000, 16'h0001};
    exp_a = '{16'hBC00, 16'h8000, 16'hFC00, 16'h3C00, 16'h8000, 16'hB400, nan_exp,  16'hFE01, 16'h8000, 16'h0001};
`ifdef HALF_ACT_NAN_PROPAGATE_EN
    exp_a[7] = 16'h7E00;
`endif
    apply_stimulus_a(2'd2);
    check_output("leaky_latency", 16'(cycles), 16'd6);
    check_vector_a("leaky");
    drain_a();

    // HARDTANH clamps magnitude to 1.0
    va_a  = '{16'h4000, 16'hC200, 16'h3800, 16'h3C00, 16'hBC00, 16'h7E01,   16'h7C00, 16'hFC00, 16'h3BFF, 16'h3C01};
    exp_a = '{16'h3C00, 16'hBC00, 16'h3800, 16'h3C00, 16'hBC00, ht_nan_exp, 16'h3C00, 16'hBC00, 16'h3BFF, 16'h3C00};
    apply_stimulus_a(2'd3);
    check_output("htanh_latency", 16'(cycles), 16'd6);
    check_vector_a("htanh");
    drain_a();

    // PASS is bit-exact apart from optional NaN canonicalisation
    va_a  = '{16'h7E01, 16'h1234, 16'hFFFF, 16'h8001, 16'h7C00, 16'hABCD, 16'h0000, 16'h8000, 16'h5555, 16'hFC01};
    exp_a = '{nan_exp,  16'h1234, 16'hFFFF, 16'h8001, 16'h7C00, 16'hABCD, 16'h0000, 16'h8000, 16'h5555, 16'hFC01};
`ifdef HALF_ACT_NAN_PROPAGATE_EN
    exp_a[2] = 16'h7E00;
    exp_a[9] = 16'h7E00;
`endif
    apply_stimulus_a(2'd0);
    check_output("pass_latency", 16'(cycles), 16'd6);
    check_vector_a("pass");
    drain_a();

    // Reset at RUN beat 2 discards the vector
    va_a = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h0123, 16'h0456, 16'h0789};
    mode_a = 2'd0;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check_output("midrun_rst_ready", {15'h0, in_ready_a}, 16'h0);
    step();
    rst = 1'b0;
    #1;
    check_output("midrun_out_valid", {15'h0, out_valid_a}, 16'h0);
    check_output("midrun_c0", vc_a[0], 16'h0000);
    check_output("midrun_c1", vc_a[1], 16'h0000);
    check_output("midrun_in_ready", {15'h0, in_ready_a}, 16'h1);
    va_a  = '{16'hC800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3C00};
    exp_a = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3C00};
    apply_stimulus_a(2'd1);
    check_output("post_rst_latency", 16'(cycles), 16'd6);
    check_vector_a("post_rst");
    drain_a();

    // Narrow instance: 3 beats with a padded slot, then a long stall on out_ready
    va_b  = '{16'h1111, 16'h9111, 16'h3333, 16'hC444, 16'h5555};
    exp_b = '{16'h1111, 16'h0000, 16'h3333, 16'h0000, 16'h5555};
    mode_b = 2'd1;
    in_valid_b = 1'b1;
    step();
    va_b = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    mode_b = 2'd0;
    cycles = 0;
    while (out_valid_b !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
    check_output("narrow_latency", 16'(cycles), 16'd4);
    for (int i = 0; i < 5; i++) check_output($sformatf("narrow_c%0d", i), vc_b[i], exp_b[i]);
    for (int k = 0; k < 10; k++) begin
      step();
      check_output($sformatf("stall%0d_valid", k), {15'h0, out_valid_b}, 16'h1);
      check_output($sformatf("stall%0d_ready", k), {15'h0, in_ready_b}, 16'h0);
      check_output($sformatf("stall%0d_c4", k), vc_b[4], 16'h5555);
    end
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
    check_output("narrow_drain_ready", {15'h0, in_ready_b}, 16'h1);
    check_output("narrow_drain_valid", {15'h0, out_valid_b}, 16'h0);
    check_output("narrow_retain_c0", vc_b[0], 16'h1111);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/half_activation_seq_v.md
HALF_ACTIVATION_SEQ_V -- requirements
Module: half_activation_seq_v

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning number of fp16 elements per vector (>=1).
REQ-002 SHALL have parameter LANES, default 2, meaning number of activation lanes (1..WIDTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, which qualifies vector_a and mode.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept a vector.
REQ-007 SHALL have port mode, input, 2, selecting the activation: 0 PASS, 1 RELU, 2 LEAKY, 3 HARDTANH.
REQ-008 SHALL have port vector_a, input, 16 x WIDTH, the input fp16 vector (unpacked array).
REQ-009 SHALL have port out_valid, output, 1, meaning vector_c holds a complete result.
REQ-010 SHALL have port out_ready, input, 1, the downstream accept.
REQ-011 SHALL have port vector_c, output, 16 x WIDTH, the registered result vector.

Function
REQ-012 SHALL use an FSM with states IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL capture vector_a and mode into internal registers on in_valid&&in_ready, then go IDLE->RUN; the mode is frozen for that vector.
REQ-014 SHALL, in RUN, issue elements beat*LANES+l to lane l on each beat, for BEATS=ceil(WIDTH/LANES) beats; padded indices >=WIDTH are discarded and never written.
REQ-015 SHALL register each lane result 1 cycle after issue, writing it into vector_c[index].
REQ-016 SHALL raise out_valid exactly BEATS+1 cycles after the accept edge (e.g. WIDTH=10, LANES=2: 6 cycles).
REQ-017 SHALL, in DONE, hold vector_c and out_valid stable until out_ready; on out_valid&&out_ready go DONE->IDLE, so in_ready is 1 the next cycle; there is no overlap of vectors.
REQ-018 SHALL leave vector_c unchanged from the previous result except for elements already written during RUN.
REQ-019 SHALL implement PASS as c=a (bit-exact).
REQ-020 SHALL implement RELU as: sign=1 -> 16'h0000 (including -0 and -inf); otherwise c=a.
REQ-021 SHALL implement LEAKY (x/8) as:
- sign=0 -> c=a.
- sign=1, exp=31 -> c=a.
- sign=1, exp>3 -> exponent minus 3, mantissa kept.
- sign=1, exp<=3 -> 16'h8000 (flush).
REQ-022 SHALL implement HARDTANH as: a[14:0]>15'h3C00 -> {a[15],15'h3C00}; otherwise c=a.
REQ-023 SHALL ignore in_valid while not in IDLE, and SHALL not sample out_ready outside DONE.

Reset
REQ-024 SHALL, on rst, set: state=IDLE, out_valid=0, all vector_c=16'h0000, beat counter=0, captured mode=0.
REQ-025 SHALL force in_ready=0 during the cycles rst is high.
REQ-026 SHALL, on rst mid-RUN or mid-DONE, discard the vector with no out_valid; in_ready is 1 the cycle after rst deasserts.

Configuration
REQ-027 SHALL, with HALF_ACT_NAN_PROPAGATE_EN defined, map any NaN input (exp=31, mantissa!=0) to 16'h7E00 in all modes, PASS included.
REQ-028 SHALL, without HALF_ACT_NAN_PROPAGATE_EN, treat NaN as an ordinary bit pattern per REQ-019..022 (e.g. HARDTANH 16'h7E01 -> 16'h3C00).

Structure
REQ-029 SHALL define in shared package half_act_pkg:
- the mode enum and FSM state enum.
- constants HALF_ONE=16'h3C00, HALF_QNAN=16'h7E00, HALF_NEG_ZERO=16'h8000.
REQ-030 SHALL instantiate LANES copies of sub-module half_act_lane (one element, mode input, 1-cycle registered output).

Verification
REQ-031 SHALL cover: WIDTH=10, LANES=2, RELU, a={3C00,BC00,0000,8000,7C00,FC00,...} -> c={3C00,0000,0000,0000,7C00,0000,...}, out_valid at cycle 6.
REQ-032 SHALL cover: LEAKY on 16'hC800 (-8) -> 16'hBC00; 16'h8C00 -> 16'h8000; 16'hFC00 -> 16'hFC00.
REQ-033 SHALL cover: HARDTANH on 16'h4000 -> 16'h3C00; 16'hC200 -> 16'hBC00; 16'h3800 -> 16'h3800.
REQ-034 SHALL cover: WIDTH=5, LANES=2 -> BEATS=3, out_valid 4 cycles after accept; out_ready held 0 for 10 cycles -> vector_c stable and in_ready=0 throughout.
REQ-035 SHALL cover: rst asserted at RUN beat 2 -> no out_valid, vector_c=0, next vector accepted the first cycle after rst.
REQ-036 SHALL cover: NaN 16'h7E01 in PASS -> 16'h7E00 with HALF_ACT_NAN_PROPAGATE_EN, 16'h7E01 without.
